// File: rtl/ejector_pkg.sv
// Shared NoC definitions: port numbering and the 6-bit flit address layout.
package ejector_pkg;

    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned PORT_W    = 2;

    // Address layout: [5:3] row, [2:0] column.
    localparam int unsigned COORD_W = 3;
    localparam int unsigned ADDR_W  = 2 * COORD_W;
    localparam int unsigned ROW_LSB = COORD_W;
    localparam int unsigned ROW_MSB = ADDR_W - 1;
    localparam int unsigned COL_LSB = 0;
    localparam int unsigned COL_MSB = COORD_W - 1;

    // Port indices, also the round-robin order.
    localparam logic [PORT_W-1:0] EAST  = 2'd0;
    localparam logic [PORT_W-1:0] WEST  = 2'd1;
    localparam logic [PORT_W-1:0] NORTH = 2'd2;
    localparam logic [PORT_W-1:0] SOUTH = 2'd3;

    // Width of the deflection counter.
    localparam int unsigned DEF_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
    } coord_t;

    // Build a flit address from router coordinates.
    function automatic addr_t make_addr(input logic [COORD_W-1:0] row,
                                        input logic [COORD_W-1:0] col);
        coord_t c;
        c.row = row;
        c.col = col;
        return addr_t'(c);
    endfunction

    // Split a flit address into its coordinates.
    function automatic coord_t split_addr(input addr_t ad);
        coord_t c;
        c.row = ad[ROW_MSB:ROW_LSB];
        c.col = ad[COL_MSB:COL_LSB];
        return c;
    endfunction

endpackage

// File: rtl/eject_fifo.sv
// Local ejection buffer: power-of-two depth, flop storage, head visible
// combinationally from the read pointer so it holds while the sink stalls.
module eject_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             din_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             dout_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_eff_c;
    logic             pop_eff_c;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Qualify requests: pop only when data present, push when space or freed by pop.
    always_comb begin
        pop_eff_c  = pop_i && !empty_o;
        push_eff_c = push_i && (!full_o || pop_eff_c);
    end

    // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_eff_c) begin
            wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
        end
        if (pop_eff_c) begin
            rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
        end
        case ({push_eff_c, pop_eff_c})
            2'b10:   count_d = CNT_W'(count_q + 1'b1);
            2'b01:   count_d = CNT_W'(count_q - 1'b1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are don't-care until covered by count.
    always_ff @(posedge clk) begin
        if (push_eff_c) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/ejector.sv
// Router ejection stage: picks at most one flit addressed to this node per
// cycle (round-robin over E/W/N/S), buffers it for the local sink, and
// registers every other slot through unchanged, counting deflected local flits.
module ejector
    import ejector_pkg::*;
#(
    parameter logic [COORD_W-1:0] NODE_ROW   = 3'd4,
    parameter logic [COORD_W-1:0] NODE_COL   = 3'd4,
    parameter int unsigned        FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] eastad,
    input  logic [ADDR_W-1:0] westad,
    input  logic [ADDR_W-1:0] northad,
    input  logic [ADDR_W-1:0] southad,
    input  logic              eastv,
    input  logic              westv,
    input  logic              northv,
    input  logic              southv,
    output logic [ADDR_W-1:0] ead,
    output logic [ADDR_W-1:0] wad,
    output logic [ADDR_W-1:0] nad,
    output logic [ADDR_W-1:0] sad,
    output logic              ev,
    output logic              wv,
    output logic              nv,
    output logic              sv,
    output logic [ADDR_W-1:0] localad,
    output logic              localv,
    input  logic              localrdy,
    output logic [DEF_W-1:0]  defcnt
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = DEF_W + 1;
    localparam addr_t       LOCAL_ADDR = make_addr(NODE_ROW, NODE_COL);

    addr_t                 in_ad [NUM_PORTS];
    logic [NUM_PORTS-1:0]  in_v;

    logic [NUM_PORTS-1:0]  match_c;
    logic [NUM_PORTS-1:0]  grant_c;
    logic [NUM_PORTS-1:0]  deflect_c;
    logic                  grant_vld_c;
    logic [PORT_W-1:0]     grant_idx_c;
    logic [PORT_W-1:0]     scan_idx_c;
    logic [2:0]            defl_num_c;
    logic [SUM_W-1:0]      def_sum_c;

    logic [PORT_W-1:0]     rr_ptr_q, rr_ptr_d;
    addr_t                 out_ad_q [NUM_PORTS];
    addr_t                 out_ad_d [NUM_PORTS];
    logic [NUM_PORTS-1:0]  out_v_q, out_v_d;
    logic [DEF_W-1:0]      defcnt_q, defcnt_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    addr_t                 fifo_dout;
    logic                  fifo_pop_c;
    logic                  can_eject_c;

    // Gather the four ports into index order.
    assign in_ad[EAST]  = eastad;
    assign in_ad[WEST]  = westad;
    assign in_ad[NORTH] = northad;
    assign in_ad[SOUTH] = southad;
    assign in_v[EAST]   = eastv;
    assign in_v[WEST]   = westv;
    assign in_v[NORTH]  = northv;
    assign in_v[SOUTH]  = southv;

    // Sink handshake and space check; a full buffer still accepts if it pops.
    always_comb begin
        fifo_pop_c  = !fifo_empty && localrdy;
        can_eject_c = !fifo_full || fifo_pop_c;
    end

    // Local-destination detection per port.
    always_comb begin
        match_c = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            match_c[i] = in_v[i] && (in_ad[i] == LOCAL_ADDR);
        end
    end

    // Round-robin grant: first match scanning upward from rr_ptr.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        scan_idx_c  = '0;
        grant_c     = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            scan_idx_c = PORT_W'(rr_ptr_q + PORT_W'(k));
            if (!grant_vld_c && can_eject_c && match_c[scan_idx_c]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = scan_idx_c;
            end
        end
        if (grant_vld_c) begin
            grant_c[grant_idx_c] = 1'b1;
        end
    end

    // Pointer moves past the winner only when something was ejected.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld_c) begin
            rr_ptr_d = PORT_W'(grant_idx_c + 1'b1);
        end
    end

    // Pass-through: ejected and idle slots leave as empty, address zeroed.
    always_comb begin
        out_v_d = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            out_v_d[i]  = in_v[i] && !grant_c[i];
            out_ad_d[i] = out_v_d[i] ? in_ad[i] : '0;
        end
    end

    // Deflection counter: add local flits that stayed in the network, saturate.
    always_comb begin
        deflect_c  = match_c & ~grant_c;
        defl_num_c = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            defl_num_c = 3'(defl_num_c + 3'(deflect_c[i]));
        end
        def_sum_c = {1'b0, defcnt_q} + SUM_W'(defl_num_c);
        defcnt_d  = def_sum_c[DEF_W] ? '1 : def_sum_c[DEF_W-1:0];
    end

    // Arbitration, pass-through and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            out_v_q  <= '0;
            defcnt_q <= '0;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                out_ad_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            out_v_q  <= out_v_d;
            defcnt_q <= defcnt_d;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                out_ad_q[i] <= out_ad_d[i];
            end
        end
    end

    eject_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (grant_vld_c),
        .din_i   (LOCAL_ADDR),
        .pop_i   (fifo_pop_c),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign ead     = out_ad_q[EAST];
    assign wad     = out_ad_q[WEST];
    assign nad     = out_ad_q[NORTH];
    assign sad     = out_ad_q[SOUTH];
    assign ev      = out_v_q[EAST];
    assign wv      = out_v_q[WEST];
    assign nv      = out_v_q[NORTH];
    assign sv      = out_v_q[SOUTH];
    assign localad = fifo_dout;
    assign localv  = (fifo_count != '0);
    assign defcnt  = defcnt_q;

endmodule

// File: tb/tb_ejector.sv
// Randomized bench for ejector with a queue-based reference model.
module tb_ejector;

    localparam logic [5:0] LOCAL = 6'b100100;
    localparam int         DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] in_ad [4];
    logic       in_v  [4];
    logic       rdy;

    logic [5:0] eastad, westad, northad, southad;
    logic       eastv, westv, northv, southv;
    logic [5:0] ead, wad, nad, sad, localad;
    logic       ev, wv, nv, sv, localv;
    logic [7:0] defcnt;
    logic [5:0] o_ad [4];
    logic       o_v  [4];

    assign eastad  = in_ad[0];
    assign westad  = in_ad[1];
    assign northad = in_ad[2];
    assign southad = in_ad[3];
    assign eastv   = in_v[0];
    assign westv   = in_v[1];
    assign northv  = in_v[2];
    assign southv  = in_v[3];
    assign o_ad[0] = ead;
    assign o_ad[1] = wad;
    assign o_ad[2] = nad;
    assign o_ad[3] = sad;
    assign o_v[0]  = ev;
    assign o_v[1]  = wv;
    assign o_v[2]  = nv;
    assign o_v[3]  = sv;

    ejector #(.NODE_ROW(3'd4), .NODE_COL(3'd4), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .eastad   (eastad),
        .westad   (westad),
        .northad  (northad),
        .southad  (southad),
        .eastv    (eastv),
        .westv    (westv),
        .northv   (northv),
        .southv   (southv),
        .ead      (ead),
        .wad      (wad),
        .nad      (nad),
        .sad      (sad),
        .ev       (ev),
        .wv       (wv),
        .nv       (nv),
        .sv       (sv),
        .localad  (localad),
        .localv   (localv),
        .localrdy (rdy),
        .defcnt   (defcnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: buffer contents, next port to favour, deflection total.
    logic [5:0] mq[$];
    int         m_rr;
    int         m_def;
    logic [5:0] e_ad [4];
    logic       e_v  [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rr  = 0;
        m_def = 0;
        for (int i = 0; i < 4; i++) begin
            e_ad[i] = 6'd0;
            e_v[i]  = 1'b0;
        end
    endtask

    // One clock of the specified behaviour, applied to the current inputs.
    task automatic model_step();
        int ej;
        int defl;
        int p;
        bit pop;
        bit room;
        ej   = -1;
        defl = 0;
        pop  = (mq.size() != 0) && rdy;
        room = (mq.size() < DEPTH) || pop;
        if (room) begin
            for (int k = 0; k < 4; k++) begin
                p = (m_rr + k) % 4;
                if (ej < 0 && in_v[p] && in_ad[p] == LOCAL) ej = p;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (in_v[i] && in_ad[i] == LOCAL && i != ej) defl++;
            e_v[i]  = in_v[i] && (i != ej);
            e_ad[i] = e_v[i] ? in_ad[i] : 6'd0;
        end
        m_def = (m_def + defl > 255) ? 255 : m_def + defl;
        if (pop) void'(mq.pop_front());
        if (ej >= 0) begin
            mq.push_back(in_ad[ej]);
            m_rr = (ej + 1) % 4;
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ad%0d", i), 32'(o_ad[i]), 32'(e_ad[i]));
            chk($sformatf("v%0d", i), 32'(o_v[i]), 32'(e_v[i]));
        end
        chk("localv", 32'(localv), 32'(mq.size() != 0));
        chk("localad", 32'(localad), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        chk("defcnt", 32'(defcnt), 32'(m_def));
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_ad%0d", tag, i), 32'(o_ad[i]), 32'd0);
            chk($sformatf("%s_v%0d", tag, i), 32'(o_v[i]), 32'd0);
        end
        chk({tag, "_localv"}, 32'(localv), 32'd0);
        chk({tag, "_localad"}, 32'(localad), 32'd0);
        chk({tag, "_defcnt"}, 32'(defcnt), 32'd0);
    endtask

    // Called at a falling edge with inputs already set.
    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 4; i++) begin
            in_ad[i] = 6'd0;
            in_v[i]  = 1'b0;
        end
    endtask

    task automatic all_local();
        for (int i = 0; i < 4; i++) begin
            in_ad[i] = LOCAL;
            in_v[i]  = 1'b1;
        end
    endtask

    // Asynchronous reset mid-cycle, held across one edge carrying local traffic.
    task automatic do_reset(input string tag);
        all_local();
        rdy = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero({tag, "_async"});
        @(posedge clk);
        @(negedge clk);
        check_zero({tag, "_edge"});
        rst_n = 1'b1;
        model_reset();
        clear_inputs();
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < 4; i++) begin
            in_v[i]  = ($urandom_range(0, 9) < 7);
            in_ad[i] = ($urandom_range(0, 1) != 0) ? LOCAL : 6'($urandom);
        end
    endtask

    int saved_def;
    int rdy_pct;

    initial begin
        rst_n = 1'b0;
        rdy   = 1'b1;
        clear_inputs();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_zero("init");
        rst_n = 1'b1;

        // Contention from rr_ptr=0 with an empty buffer.
        all_local();
        rdy = 1'b0;
        step();
        chk("cont1_ev", 32'(ev), 32'd0);
        chk("cont1_ead", 32'(ead), 32'd0);
        chk("cont1_wv", 32'(wv), 32'd1);
        chk("cont1_nv", 32'(nv), 32'd1);
        chk("cont1_sv", 32'(sv), 32'd1);
        chk("cont1_def", 32'(defcnt), 32'd3);
        step();
        chk("cont2_wv", 32'(wv), 32'd0);
        chk("cont2_ev", 32'(ev), 32'd1);
        chk("cont2_def", 32'(defcnt), 32'd6);

        // Drain, then a flit for another node.
        clear_inputs();
        rdy = 1'b1;
        repeat (3) step();
        chk("drained_localv", 32'(localv), 32'd0);
        in_ad[1] = 6'b011101;
        in_v[1]  = 1'b1;
        step();
        chk("nonlocal_wad", 32'(wad), 32'(6'b011101));
        chk("nonlocal_wv", 32'(wv), 32'd1);
        chk("nonlocal_localv", 32'(localv), 32'd0);
        chk("nonlocal_def", 32'(defcnt), 32'd6);

        // Single ejection from north.
        clear_inputs();
        rdy = 1'b0;
        in_ad[2] = LOCAL;
        in_v[2]  = 1'b1;
        step();
        chk("single_nv", 32'(nv), 32'd0);
        chk("single_nad", 32'(nad), 32'd0);
        chk("single_localv", 32'(localv), 32'd1);
        chk("single_localad", 32'(localad), 32'(LOCAL));

        // Fill the buffer, then probe full with and without a pop.
        clear_inputs();
        rdy = 1'b1;
        repeat (2) step();
        rdy = 1'b0;
        in_ad[0] = LOCAL;
        in_v[0]  = 1'b1;
        repeat (DEPTH) step();
        saved_def = m_def;
        step();
        chk("full_ev", 32'(ev), 32'd1);
        chk("full_ead", 32'(ead), 32'(LOCAL));
        chk("full_def", 32'(defcnt), 32'(saved_def + 1));
        rdy = 1'b1;
        step();
        chk("fullpop_ev", 32'(ev), 32'd0);
        chk("fullpop_def", 32'(defcnt), 32'(saved_def + 1));
        clear_inputs();
        repeat (DEPTH) step();
        chk("fullpop_drain", 32'(localv), 32'd0);

        // Randomized traffic with a reset in the middle.
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) rdy_pct = $urandom_range(10, 90);
            if (c == 700) do_reset("mid");
            randomize_inputs();
            rdy = ($urandom_range(0, 99) < rdy_pct);
            step();
        end

        // Sustained deflection saturates the counter.
        do_reset("sat");
        all_local();
        rdy = 1'b0;
        repeat (70) step();
        chk("sat_defcnt", 32'(defcnt), 32'hFF);
        step();
        chk("sat_hold", 32'(defcnt), 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
